// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: shared state encoding and default pattern
// for the serial pattern generator and its detector.
package seq_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [5:0] DEFAULT_PAT = 6'b110101;

endpackage

// File: rtl/seq_pattern_gen_if.sv
// seq_pattern_gen_if: request and serial output bundle
// between a pattern generator and its requester.
interface seq_pattern_gen_if #(
    parameter int PAT_W = 6,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
);
    logic             start;
    logic             use_default;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] repeat_cnt;
    logic [GAP_W-1:0] gap_len;
    logic             x_out;
    logic             x_valid;
    logic             frame_start;
    logic             busy;
    logic             done;

    modport master (
        output start, use_default, pattern,
        output repeat_cnt, gap_len,
        input  x_out, x_valid, frame_start,
        input  busy, done
    );

    modport slave (
        input  start, use_default, pattern,
        input  repeat_cnt, gap_len,
        output x_out, x_valid, frame_start,
        output busy, done
    );
endinterface

// File: rtl/seq_shift_ser.sv
// seq_shift_ser: parallel-load MSB-first shifter with a
// bit counter flagging the first and last bit of a frame.
module seq_shift_ser #(
    parameter int PAT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] load_val,
    output logic             msb,
    output logic             first_bit,
    output logic             last_bit
);
    localparam int BW = $clog2(PAT_W);
    localparam logic [BW-1:0] TOP = BW'(PAT_W - 1);

    logic [PAT_W-1:0] sr_q, sr_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;

    // load wins so a back-to-back reload overrides the shift
    always_comb begin
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        if (load) begin
            sr_d      = load_val;
            bit_cnt_d = TOP;
        end else if (shift) begin
            sr_d      = {sr_q[PAT_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q - BW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q      <= '0;
            bit_cnt_q <= '0;
        end else begin
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign msb       = sr_q[PAT_W-1];
    assign first_bit = (bit_cnt_q == TOP);
    assign last_bit  = (bit_cnt_q == '0);
endmodule

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: Moore serial pattern generator that sends
// a latched pattern a latched number of times with gaps.
module seq_pattern_gen #(
    parameter int               PAT_W       = 6,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = seq_gen_pkg::DEFAULT_PAT,
    parameter int               CNT_W       = 8,
    parameter int               GAP_W       = 4
) (
    input logic               clk,
    input logic               rst,
    seq_pattern_gen_if.slave  bus
);
    import seq_gen_pkg::*;

    state_e           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [CNT_W-1:0] frames_q, frames_d;
    logic [GAP_W-1:0] gap_len_q, gap_len_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

    logic             load, shift;
    logic [PAT_W-1:0] load_val, pat_sel;
    logic             msb, first_bit, last_bit;

    assign pat_sel = bus.use_default ? DEFAULT_PAT : bus.pattern;

    seq_shift_ser #(.PAT_W(PAT_W)) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .shift     (shift),
        .load_val  (load_val),
        .msb       (msb),
        .first_bit (first_bit),
        .last_bit  (last_bit)
    );

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        frames_d  = frames_q;
        gap_len_d = gap_len_q;
        gap_cnt_d = gap_cnt_q;
        load      = 1'b0;
        shift     = 1'b0;
        load_val  = pat_q;
        unique case (state_q)
            IDLE: if (bus.start) begin
                pat_d     = pat_sel;
                frames_d  = bus.repeat_cnt;
                gap_len_d = bus.gap_len;
                load      = 1'b1;
                load_val  = pat_sel;
                state_d   = (bus.repeat_cnt != '0) ? SEND : DONE;
            end
            SEND: begin
                shift = 1'b1;
                if (last_bit) begin
                    frames_d = frames_q - CNT_W'(1);
                    if (frames_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end else if (gap_len_q != '0) begin
                        state_d   = GAP;
                        gap_cnt_d = gap_len_q - GAP_W'(1);
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q - GAP_W'(1);
                if (gap_cnt_q == '0) begin
                    load    = 1'b1;
                    state_d = SEND;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            frames_q  <= '0;
            gap_len_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            frames_q  <= frames_d;
            gap_len_q <= gap_len_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign bus.x_valid     = (state_q == SEND);
    assign bus.x_out       = bus.x_valid & msb;
    assign bus.frame_start = bus.x_valid & first_bit;
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == DONE);
endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb_seq_pattern_gen: directed scoreboard bench for the
// serial pattern generator.
module tb_seq_pattern_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;

    seq_pattern_gen_if #(.PAT_W(6), .CNT_W(8), .GAP_W(4)) bus ();

    seq_pattern_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // {x_out, x_valid, frame_start, busy, done}
    logic [4:0] sb[$];
    int vec = 0;
    int miscompares = 0;

    function automatic logic [4:0] obs_vec();
        return {bus.x_out, bus.x_valid, bus.frame_start,
                bus.busy, bus.done};
    endfunction

    task automatic check_now(input string tag,
                             input logic [4:0] exp);
        logic [4:0] obs;
        obs = obs_vec();
        vec++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag);
        @(negedge clk);
        if (sb.size() == 0) begin
            vec++;
            miscompares++;
            $error("FAIL %s observed=%b expected=<empty scoreboard>",
                   tag, obs_vec());
        end else begin
            check_now(tag, sb.pop_front());
        end
    endtask

    task automatic run_all(input string tag);
        while (sb.size() > 0) step(tag);
    endtask

    task automatic expect_req(input logic [5:0] pat,
                              input int rep, input int gap);
        for (int f = 0; f < rep; f++) begin
            for (int b = 0; b < 6; b++)
                sb.push_back({pat[5-b], 1'b1, (b == 0), 1'b1, 1'b0});
            if (f < rep - 1)
                for (int g = 0; g < gap; g++) sb.push_back(5'b00010);
        end
        sb.push_back(5'b00011);
        sb.push_back(5'b00000);
    endtask

    task automatic launch(input logic ud, input logic [5:0] pat,
                          input int rep, input int gap);
        logic [5:0] sent;
        @(negedge clk);
        bus.use_default = ud;
        bus.pattern     = pat;
        bus.repeat_cnt  = 8'(rep);
        bus.gap_len     = 4'(gap);
        bus.start       = 1'b1;
        sent = ud ? 6'b110101 : pat;
        expect_req(sent, rep, gap);
        @(posedge clk);
        #1 bus.start = 1'b0;
        bus.pattern    = ~pat;
        bus.repeat_cnt = 8'd5;
        bus.gap_len    = 4'd7;
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.use_default = 1'b0;
        bus.pattern     = '0;
        bus.repeat_cnt  = '0;
        bus.gap_len     = '0;

        #2 check_now("reset_outputs", 5'b00000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.push_back(5'b00000);
        step("idle_after_reset");

        launch(1'b1, 6'b000000, 1, 0);
        run_all("single_frame");

        launch(1'b1, 6'b000000, 3, 1);
        run_all("repeat_gap1");

        launch(1'b0, 6'b101100, 2, 0);
        run_all("back_to_back");

        launch(1'b0, 6'b111111, 0, 3);
        run_all("zero_count");

        launch(1'b0, 6'b011001, 2, 3);
        run_all("gap3_user");

        launch(1'b1, 6'b000000, 2, 0);
        repeat (3) step("busy_start_pre");
        bus.start       = 1'b1;
        bus.use_default = 1'b0;
        bus.pattern     = 6'b000000;
        step("busy_start_hit");
        bus.start = 1'b0;
        while (sb.size() > 2) step("busy_start_rest");
        step("busy_start_done");
        bus.start = 1'b1;
        step("busy_start_done_held");
        bus.start = 1'b0;
        sb.push_back(5'b00000);
        step("busy_start_no_retrigger");

        launch(1'b1, 6'b000000, 1, 0);
        repeat (3) step("reset_mid_pre");
        #2 rst = 1'b1;
        #1 check_now("reset_mid_async", 5'b00000);
        sb.delete();
        @(negedge clk);
        check_now("reset_mid_held", 5'b00000);
        rst = 1'b0;
        sb.push_back(5'b00000);
        step("reset_mid_no_done");
        launch(1'b0, 6'b100111, 1, 0);
        run_all("after_reset_frame");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vec, miscompares);
        $finish;
    end
endmodule
